cordic_fsm_param: RTL and testbench
===================================

# cordic_fsm_param

Parametrised control FSM for the iterative CORDIC sine/cosine datapath. It owns the iteration and variable counters internally, with a parameter-set iteration count. It sequences the input, shift, LUT and sign registers and runs one add/sub handshake per variable (X, Y, Z) per iteration. It selects the output variable according to operation and quadrant shift, then holds the result until the consumer acknowledges.

## Interface
Parameters:
- ITER, 26: CORDIC iterations, ≥1; IW = max(1, $clog2(ITER))
- TIMEOUT, 255: max cycles in WAIT before error (used only with CORDIC_TIMEOUT_EN)

Ports (name, direction, width, meaning):
- clk, in, 1: system clock
- reset, in, 1: synchronous, active-low reset
- beg_FSM_CORDIC, in, 1: start request, sampled in IDLE only
- ACK_FSM_CORDIC, in, 1: consumer accepted result/error
- operation, in, 1: 0 cosine, 1 sine
- mode_in, in, 1: 0 rotation, 1 vectoring
- shift_region_flag, in, 2: quadrant shift applied to the input angle
- ready_add_subt, in, 1: add/sub result valid
- ready_CORDIC, out, 1: result valid in output register
- err_CORDIC, out, 1: add/sub timeout
- beg_add_subt / ack_add_subt, out, 1 each: add/sub start / result taken
- iter_cnt, out, IW: current iteration; drives shift amount and LUT address
- sel_mux_2, out, 2: current variable (0 X, 1 Y, 2 Z)
- sel_mux_1, out, 1: 0 on iteration 0, 1 otherwise
- sel_mux_3, out, 1: output variable (0 X, 1 Y)
- mode, out, 1: latched mode_in
- enab_RB1, enab_RB2, enab_dff_shifted_x, enab_dff_shifted_y, enab_dff_LUT, enab_dff_sign, enab_d_ff_Xn, enab_d_ff_Yn, enab_d_ff_Zn, enab_dff5, enab_d_ff_out, out, 1 each: register enables

## Operation
- The state register and counters are the only sequential elements apart from the latches below. All outputs are decoded from the state (Moore).
- operation, mode_in and shift_region_flag are latched in LOAD.
- States and transitions:
  - IDLE: go to LOAD when beg_FSM_CORDIC=1; clear iter_cnt and var counter.
  - LOAD: enab_RB1=1; go to MUX.
  - MUX: enab_RB2=1, sel_mux_1=(iter_cnt≠0); go to SHIFT.
  - SHIFT: enab_dff_shifted_x/y, enab_dff_LUT and enab_dff_sign =1; go to BEG.
  - BEG: beg_add_subt=1; go to WAIT.
  - WAIT: stay until ready_add_subt=1, then go to STORE.
  - STORE: ack_add_subt=1 and the enab_d_ff_{Xn,Yn,Zn} selected by the var counter =1.
    - var<2: var+1, go to BEG.
    - var=2 and iter_cnt<ITER-1: iter+1, var=0, go to MUX.
    - Otherwise: go to SEL.
  - SEL: enab_dff5=1; go to OUT.
  - OUT: enab_d_ff_out=1; go to DONE.
  - DONE: ready_CORDIC=1; go to IDLE when ACK_FSM_CORDIC=1.
- sel_mux_3 = latched operation XOR (region[1] XOR region[0]). Regions 01 and 10 swap X/Y; 00 and 11 do not. It is held from LOAD until the next LOAD.
- beg_FSM_CORDIC outside IDLE is ignored.
- If beg and ACK are both high in DONE, go to IDLE only; beg is re-sampled next cycle.
- After STORE with var=2 at iteration ITER-1, iter_cnt does not wrap and stays at ITER-1 until IDLE.

## Timing
- Reset (reset=0 at an edge) puts the FSM in IDLE and clears every output, counter and latch to 0, including mid-operation. An add/sub in flight is abandoned.
- Edge 0 samples beg. MUX of iteration i begins at edge 1+11i when ready_add_subt is high in the first WAIT cycle.
- Each extra WAIT cycle adds 1 cycle.
- ready_CORDIC rises at edge 3+11·ITER; ITER=4 gives edge 47.
- beg_add_subt and ack_add_subt are exactly one cycle wide. There are 3·ITER of each per operation.

## Configuration
- CORDIC_TIMEOUT_EN defined:
  - An 8+-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - On reaching TIMEOUT without ready_add_subt, go to ERR: err_CORDIC=1, all other outputs 0.
  - ERR goes to IDLE when ACK_FSM_CORDIC=1.
- CORDIC_TIMEOUT_EN undefined: no counter or ERR state; err_CORDIC is tied to 0 and WAIT waits indefinitely.

## Test plan
- Hold reset=0 for 2 edges mid-operation → at the next edge every output is 0 and the FSM is in IDLE; beg 1 cycle later → LOAD.
- ITER=4, ready_add_subt tied 1, operation=0, region=00 → ready_CORDIC at edge 47; 12 beg_add_subt pulses; 4 pulses each on Xn/Yn/Zn enables; sel_mux_1=0 only in iteration 0; sel_mux_3=0.
- operation=1 with region=00, 01, 10, 11 → sel_mux_3 = 1, 0, 0, 1 respectively.
- ready_add_subt asserted 5 cycles after each beg_add_subt, ITER=4 → ready_CORDIC at edge 47+12·4=95; beg_FSM_CORDIC pulsed mid-run has no effect.
- DONE with ACK held 0 for 10 cycles → ready_CORDIC stays 1; ACK=1 → IDLE next edge, ready_CORDIC=0.
- CORDIC_TIMEOUT_EN, TIMEOUT=16, ready never asserted → err_CORDIC=1 after 16 WAIT cycles; ACK → IDLE. Without the macro → FSM remains in WAIT, err_CORDIC=0.

Source files
------------

// File: rtl/cordic_fsm_param.sv
// Control FSM for the iterative CORDIC sine/cosine datapath: sequences register enables and
// one add/sub handshake per variable per iteration. Define CORDIC_TIMEOUT_EN for the add/sub timeout.
module cordic_fsm_param #(
    parameter int ITER    = 26,
    parameter int TIMEOUT = 255,
    localparam int IW     = (ITER > 1) ? $clog2(ITER) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          beg_FSM_CORDIC,
    input  logic          ACK_FSM_CORDIC,
    input  logic          operation,
    input  logic          mode_in,
    input  logic [1:0]    shift_region_flag,
    input  logic          ready_add_subt,
    output logic          ready_CORDIC,
    output logic          err_CORDIC,
    output logic          beg_add_subt,
    output logic          ack_add_subt,
    output logic [IW-1:0] iter_cnt,
    output logic [1:0]    sel_mux_2,
    output logic          sel_mux_1,
    output logic          sel_mux_3,
    output logic          mode,
    output logic          enab_RB1,
    output logic          enab_RB2,
    output logic          enab_dff_shifted_x,
    output logic          enab_dff_shifted_y,
    output logic          enab_dff_LUT,
    output logic          enab_dff_sign,
    output logic          enab_d_ff_Xn,
    output logic          enab_d_ff_Yn,
    output logic          enab_d_ff_Zn,
    output logic          enab_dff5,
    output logic          enab_d_ff_out
);

    if (ITER < 1 || TIMEOUT < 1) begin : g_param_check
        $error("cordic_fsm_param: ITER and TIMEOUT must both be at least 1");
    end

    localparam logic [IW-1:0] ITER_LAST = IW'(ITER - 1);
    localparam logic [1:0]    VAR_Z     = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_MUX,
        S_SHIFT,
        S_BEG,
        S_WAIT,
        S_STORE,
        S_SEL,
        S_OUT,
        S_DONE
`ifdef CORDIC_TIMEOUT_EN
        , S_ERR
`endif
    } state_t;

    state_t        state, state_next;
    logic [IW-1:0] iter_q, iter_next;
    logic [1:0]    var_q, var_next;
    logic          sel3_q;
    logic          mode_q;

`ifdef CORDIC_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] to_q;

    // Cleared while in BEG so each WAIT visit starts counting from zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            to_q <= '0;
        end else if (state == S_BEG) begin
            to_q <= '0;
        end else if (state == S_WAIT) begin
            to_q <= to_q + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values, whatever the statement order.
        if (!reset) begin
            state  <= S_IDLE;
            iter_q <= '0;
            var_q  <= '0;
            sel3_q <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            state  <= state_next;
            iter_q <= iter_next;
            var_q  <= var_next;
            if (state == S_LOAD) begin
                // Regions 01 and 10 swap the roles of X and Y.
                sel3_q <= operation ^ (shift_region_flag[1] ^ shift_region_flag[0]);
                mode_q <= mode_in;
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case can infer a latch.
        state_next         = state;
        iter_next          = iter_q;
        var_next           = var_q;
        ready_CORDIC       = 1'b0;
        err_CORDIC         = 1'b0;
        beg_add_subt       = 1'b0;
        ack_add_subt       = 1'b0;
        iter_cnt           = iter_q;
        sel_mux_2          = var_q;
        sel_mux_1          = 1'b0;
        sel_mux_3          = sel3_q;
        mode               = mode_q;
        enab_RB1           = 1'b0;
        enab_RB2           = 1'b0;
        enab_dff_shifted_x = 1'b0;
        enab_dff_shifted_y = 1'b0;
        enab_dff_LUT       = 1'b0;
        enab_dff_sign      = 1'b0;
        enab_d_ff_Xn       = 1'b0;
        enab_d_ff_Yn       = 1'b0;
        enab_d_ff_Zn       = 1'b0;
        enab_dff5          = 1'b0;
        enab_d_ff_out      = 1'b0;

        unique case (state)
            S_IDLE: begin
                iter_next = '0;
                var_next  = '0;
                if (beg_FSM_CORDIC) state_next = S_LOAD;
            end
            S_LOAD: begin
                enab_RB1   = 1'b1;
                state_next = S_MUX;
            end
            S_MUX: begin
                enab_RB2   = 1'b1;
                sel_mux_1  = (iter_q != '0);
                state_next = S_SHIFT;
            end
            S_SHIFT: begin
                enab_dff_shifted_x = 1'b1;
                enab_dff_shifted_y = 1'b1;
                enab_dff_LUT       = 1'b1;
                enab_dff_sign      = 1'b1;
                state_next         = S_BEG;
            end
            S_BEG: begin
                beg_add_subt = 1'b1;
                state_next   = S_WAIT;
            end
            S_WAIT: begin
                if (ready_add_subt) begin
                    state_next = S_STORE;
`ifdef CORDIC_TIMEOUT_EN
                end else if (to_q == TO_LAST) begin
                    state_next = S_ERR;
`endif
                end
            end
            S_STORE: begin
                ack_add_subt = 1'b1;
                unique case (var_q)
                    2'd0:    enab_d_ff_Xn = 1'b1;
                    2'd1:    enab_d_ff_Yn = 1'b1;
                    default: enab_d_ff_Zn = 1'b1;
                endcase
                if (var_q != VAR_Z) begin
                    var_next   = var_q + 1'b1;
                    state_next = S_BEG;
                end else if (iter_q != ITER_LAST) begin
                    iter_next  = iter_q + 1'b1;
                    var_next   = '0;
                    state_next = S_MUX;
                end else begin
                    state_next = S_SEL;
                end
            end
            S_SEL: begin
                enab_dff5  = 1'b1;
                state_next = S_OUT;
            end
            S_OUT: begin
                enab_d_ff_out = 1'b1;
                state_next    = S_DONE;
            end
            S_DONE: begin
                ready_CORDIC = 1'b1;
                if (ACK_FSM_CORDIC) begin
                    iter_next  = '0;
                    var_next   = '0;
                    state_next = S_IDLE;
                end
            end
`ifdef CORDIC_TIMEOUT_EN
            S_ERR: begin
                err_CORDIC = 1'b1;
                iter_cnt   = '0;
                sel_mux_2  = '0;
                sel_mux_3  = 1'b0;
                mode       = 1'b0;
                if (ACK_FSM_CORDIC) begin
                    iter_next  = '0;
                    var_next   = '0;
                    state_next = S_IDLE;
                end
            end
`endif
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cordic_fsm_param.sv
// Self-checking bench for cordic_fsm_param (ITER=4, TIMEOUT=16): vector table, random runs
// against a latency/pulse-count model, reset, DONE/ACK and timeout sequences.
module tb_cordic_fsm_param;

    localparam int ITER    = 4;
    localparam int TIMEOUT = 16;
    localparam int IW      = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          beg_FSM_CORDIC = 1'b0;
    logic          ACK_FSM_CORDIC = 1'b0;
    logic          operation = 1'b0;
    logic          mode_in = 1'b0;
    logic [1:0]    shift_region_flag = 2'b00;
    logic          ready_add_subt = 1'b0;
    logic          ready_CORDIC, err_CORDIC, beg_add_subt, ack_add_subt;
    logic [IW-1:0] iter_cnt;
    logic [1:0]    sel_mux_2;
    logic          sel_mux_1, sel_mux_3, mode;
    logic          enab_RB1, enab_RB2, enab_dff_shifted_x, enab_dff_shifted_y, enab_dff_LUT;
    logic          enab_dff_sign, enab_d_ff_Xn, enab_d_ff_Yn, enab_d_ff_Zn, enab_dff5, enab_d_ff_out;

    cordic_fsm_param #(.ITER(ITER), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .beg_FSM_CORDIC(beg_FSM_CORDIC), .ACK_FSM_CORDIC(ACK_FSM_CORDIC),
        .operation(operation), .mode_in(mode_in), .shift_region_flag(shift_region_flag),
        .ready_add_subt(ready_add_subt), .ready_CORDIC(ready_CORDIC), .err_CORDIC(err_CORDIC),
        .beg_add_subt(beg_add_subt), .ack_add_subt(ack_add_subt), .iter_cnt(iter_cnt),
        .sel_mux_2(sel_mux_2), .sel_mux_1(sel_mux_1), .sel_mux_3(sel_mux_3), .mode(mode),
        .enab_RB1(enab_RB1), .enab_RB2(enab_RB2), .enab_dff_shifted_x(enab_dff_shifted_x),
        .enab_dff_shifted_y(enab_dff_shifted_y), .enab_dff_LUT(enab_dff_LUT),
        .enab_dff_sign(enab_dff_sign), .enab_d_ff_Xn(enab_d_ff_Xn), .enab_d_ff_Yn(enab_d_ff_Yn),
        .enab_d_ff_Zn(enab_d_ff_Zn), .enab_dff5(enab_dff5), .enab_d_ff_out(enab_d_ff_out)
    );

    always #5 clk = ~clk;

    logic [IW+18:0] other_out;
    logic [IW+19:0] all_out;
    assign other_out = {ready_CORDIC, beg_add_subt, ack_add_subt, iter_cnt, sel_mux_2, sel_mux_1,
                        sel_mux_3, mode, enab_RB1, enab_RB2, enab_dff_shifted_x, enab_dff_shifted_y,
                        enab_dff_LUT, enab_dff_sign, enab_d_ff_Xn, enab_d_ff_Yn, enab_d_ff_Zn,
                        enab_dff5, enab_d_ff_out};
    assign all_out = {err_CORDIC, other_out};

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: output variable select and cycle count from the operating rules.
    function automatic logic model_sel3(input logic op, input logic [1:0] rg);
        return op ^ ((rg == 2'b01) || (rg == 2'b10));
    endfunction

    // Per iteration: MUX + SHIFT, then three (BEG + dly WAIT cycles + STORE).
    function automatic int model_latency(input int dly);
        return 3 + ITER * (2 + 3 * (dly + 2));
    endfunction

    typedef struct {
        logic       op;
        logic [1:0] rg;
        logic       md;
        int         dly;
        int         ack_wait;
        bit         mid_beg;
        bit         beg_ack;
        logic       exp_sel3;
        int         exp_lat;
    } vec_t;

    vec_t tbl[8];

    task automatic run_op(input vec_t v);
        int   e = 0;
        int   since = -1;
        int   nb = 0, na = 0, nx = 0, ny = 0, nz = 0, n_mux = 0;
        bit   sel1_ok = 1'b1;
        bit   hold_ok = 1'b1;
        operation         = v.op;
        shift_region_flag = v.rg;
        mode_in           = v.md;
        ready_add_subt    = 1'b0;
        beg_FSM_CORDIC    = 1'b1;
        step();
        beg_FSM_CORDIC = 1'b0;
        while (e < v.exp_lat + 60) begin
            step();
            e++;
            if (e == 1) begin
                operation         = ~v.op;
                shift_region_flag = ~v.rg;
                mode_in           = ~v.md;
            end
            if (v.mid_beg) beg_FSM_CORDIC = (e == 20);
            nb += int'(beg_add_subt);
            na += int'(ack_add_subt);
            nx += int'(enab_d_ff_Xn);
            ny += int'(enab_d_ff_Yn);
            nz += int'(enab_d_ff_Zn);
            if (enab_RB2) begin
                if (sel_mux_1 !== (n_mux != 0)) sel1_ok = 1'b0;
                n_mux++;
            end
            if (beg_add_subt) since = 0;
            else if (since >= 0 && since < 1000) since++;
            ready_add_subt = (since >= v.dly);
            if (ready_CORDIC) break;
        end
        beg_FSM_CORDIC = 1'b0;
        ready_add_subt = 1'b0;
        check("ready_CORDIC latency", e, v.exp_lat);
        check("beg_add_subt pulses", nb, 3 * ITER);
        check("ack_add_subt pulses", na, 3 * ITER);
        check("Xn/Yn/Zn enables", {nx[7:0], ny[7:0], nz[7:0]}, {8'(ITER), 8'(ITER), 8'(ITER)});
        check("sel_mux_1 per iteration", {sel1_ok, n_mux[7:0]}, {1'b1, 8'(ITER)});
        check("sel_mux_3", sel_mux_3, v.exp_sel3);
        check("mode latched", mode, v.md);
        check("iter_cnt held at last", iter_cnt, ITER - 1);
        for (int i = 0; i < v.ack_wait; i++) begin
            step();
            if (ready_CORDIC !== 1'b1) hold_ok = 1'b0;
        end
        if (v.ack_wait > 0) check("ready_CORDIC held without ACK", hold_ok, 1'b1);
        ACK_FSM_CORDIC = 1'b1;
        if (v.beg_ack) beg_FSM_CORDIC = 1'b1;
        step();
        ACK_FSM_CORDIC = 1'b0;
        check("after ACK ready/RB1/iter", {ready_CORDIC, enab_RB1, iter_cnt}, '0);
        if (v.beg_ack) begin
            step();
            check("beg re-sampled after ACK", enab_RB1, 1'b1);
            beg_FSM_CORDIC = 1'b0;
        end
    endtask

    initial begin
        vec_t rv;
        bit   seen;
        int   w;

        tbl[0] = '{1'b0, 2'b00, 1'b0, 1, 0,  1'b0, 1'b0, 1'b0, 47};
        tbl[1] = '{1'b1, 2'b00, 1'b1, 1, 0,  1'b0, 1'b0, 1'b1, 47};
        tbl[2] = '{1'b1, 2'b01, 1'b0, 1, 1,  1'b0, 1'b0, 1'b0, 47};
        tbl[3] = '{1'b1, 2'b10, 1'b1, 1, 0,  1'b0, 1'b0, 1'b0, 47};
        tbl[4] = '{1'b1, 2'b11, 1'b0, 1, 0,  1'b0, 1'b0, 1'b1, 47};
        tbl[5] = '{1'b0, 2'b01, 1'b1, 5, 0,  1'b1, 1'b0, 1'b1, 95};
        tbl[6] = '{1'b0, 2'b11, 1'b0, 2, 10, 1'b0, 1'b0, 1'b0, 59};
        tbl[7] = '{1'b1, 2'b10, 1'b1, 1, 2,  1'b0, 1'b1, 1'b0, 47};

        reset = 1'b0;
        step();
        step();
        check("reset state", all_out, '0);
        reset = 1'b1;
        step();
        check("idle without beg", all_out, '0);

        for (int i = 0; i < 8; i++) begin
            rv.op       = 1'($urandom);
            rv.rg       = 2'($urandom);
            rv.md       = 1'($urandom);
            rv.dly      = int'($urandom_range(1, 6));
            rv.ack_wait = int'($urandom_range(0, 3));
            rv.mid_beg  = 1'($urandom);
            rv.beg_ack  = 1'b0;
            rv.exp_sel3 = model_sel3(rv.op, rv.rg);
            rv.exp_lat  = model_latency(rv.dly);
            run_op(rv);
        end

        for (int i = 0; i < 8; i++) run_op(tbl[i]);

        // tbl[7] leaves the FSM running; reset it mid-operation.
        for (int i = 0; i < 10; i++) step();
        reset = 1'b0;
        step();
        check("mid-op reset edge 1", all_out, '0);
        step();
        check("mid-op reset edge 2", all_out, '0);
        reset = 1'b1;
        beg_FSM_CORDIC = 1'b1;
        step();
        check("LOAD after reset release", enab_RB1, 1'b1);
        beg_FSM_CORDIC = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;

        // Add/sub never answers.
        operation = 1'b0;
        shift_region_flag = 2'b00;
        mode_in = 1'b0;
        ready_add_subt = 1'b0;
        beg_FSM_CORDIC = 1'b1;
        step();
        beg_FSM_CORDIC = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            step();
            if (beg_add_subt) seen = 1'b1;
        end
        check("beg_add_subt before stall", seen, 1'b1);
`ifdef CORDIC_TIMEOUT_EN
        w = 0;
        for (int i = 0; i < TIMEOUT + 20; i++) begin
            step();
            if (err_CORDIC) break;
            w++;
        end
        check("WAIT cycles before err", w, TIMEOUT);
        check("err_CORDIC", err_CORDIC, 1'b1);
        check("other outputs in ERR", other_out, '0);
        step();
        check("ERR held without ACK", err_CORDIC, 1'b1);
        ACK_FSM_CORDIC = 1'b1;
        step();
        ACK_FSM_CORDIC = 1'b0;
        check("IDLE after ERR ACK", all_out, '0);
`else
        w = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (err_CORDIC || ack_add_subt || ready_CORDIC || beg_add_subt) w++;
        end
        check("stuck in WAIT without timeout", w, 0);
        check("err_CORDIC tied low", err_CORDIC, 1'b0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("reset out of WAIT", all_out, '0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
